// File: rtl/prdec_pkg.sv
// Shared types and helpers for the priority-decoder sequencer.
// Default widths match the 6-input priority encoder upstream.
package prdec_pkg;

  localparam int N_OUT_DEF  = 6;
  localparam int CODE_W_DEF = 3;
  localparam int GAP_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } state_t;

  // Wide one-hot; callers truncate to their own output width.
  function automatic logic [63:0] code2onehot(input logic [7:0] code);
    return 64'd1 << code;
  endfunction

endpackage

// File: rtl/prdec_fifo.sv
// Small synchronous FIFO holding legal codes between the input filter and the replay FSM.
// Pointers wrap modulo DEPTH; the registered count spans 0..DEPTH.
module prdec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/prdec_seq.sv
// Replays buffered (code, valid) tokens from the priority encoder as one-hot request vectors.
// Define PRDEC_STATS_EN to add drop_cnt_o, a saturating count of tokens discarded at the input.
module prdec_seq
  import prdec_pkg::*;
#(
  parameter int N_OUT   = N_OUT_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_i,
  input  logic              v_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  o,
  output logic              err_o,
  input  logic              err_clr
`ifdef PRDEC_STATS_EN
  ,
  output logic [7:0]        drop_cnt_o
`endif
);

  localparam logic [CODE_W:0]    N_OUT_C  = (CODE_W + 1)'(N_OUT);
  localparam logic [GAP_W-1:0]   GAP_INIT = GAP_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

  logic              fifo_full;
  logic              fifo_empty;
  logic [CODE_W-1:0] fifo_code;
  logic              accept;
  logic              code_ok;
  logic              illegal;
  logic              push;
  logic              pop;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              out_valid_d;
  logic [N_OUT-1:0]  o_d;

  // in_ready follows the registered full flag only, so a pop never frees a slot in the same cycle.
  assign in_ready = !rst && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign code_ok  = ({1'b0, code_i} < N_OUT_C);
  assign illegal  = v_i && !code_ok;
  assign push     = accept && v_i && code_ok;

  prdec_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (code_i),
    .rdata (fifo_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A fresh illegal token outranks a clear request in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (accept && illegal) begin
      err_o <= 1'b1;
    end else if (err_clr) begin
      err_o <= 1'b0;
    end
  end

`ifdef PRDEC_STATS_EN
  logic drop;
  assign drop = accept && !(v_i && code_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      out_valid <= 1'b0;
      o         <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      out_valid <= out_valid_d;
      o         <= o_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    out_valid_d = out_valid;
    o_d         = o;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          o_d         = N_OUT'(code2onehot(8'(fifo_code)));
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          o_d         = '0;
          if (GAP_CYC > 0) begin
            gap_d   = GAP_INIT;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prdec_seq.sv
// Directed self-checking bench for prdec_seq; a second instance with GAP_CYC=3 checks the idle gap.
// drop_cnt_o checks are compiled in only when PRDEC_STATS_EN is defined.
module tb_prdec_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] code_i;
  logic       v_i;
  logic       out_ready;
  logic       err_clr;

  logic       in_ready,  in_ready_g;
  logic       out_valid, out_valid_g;
  logic [5:0] o,         o_g;
  logic       err_o,     err_o_g;
`ifdef PRDEC_STATS_EN
  logic [7:0] drop_cnt,  drop_cnt_g;
`endif

  int compared   = 0;
  int mismatched = 0;

  prdec_seq #(.N_OUT(6), .CODE_W(3), .DEPTH(4), .GAP_CYC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_i    (code_i),
    .v_i       (v_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .err_o     (err_o),
    .err_clr   (err_clr)
`ifdef PRDEC_STATS_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  prdec_seq #(.N_OUT(6), .CODE_W(3), .DEPTH(4), .GAP_CYC(3)) dut_gap (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_g),
    .code_i    (code_i),
    .v_i       (v_i),
    .out_valid (out_valid_g),
    .out_ready (out_ready),
    .o         (o_g),
    .err_o     (err_o_g),
    .err_clr   (err_clr)
`ifdef PRDEC_STATS_EN
    ,
    .drop_cnt_o (drop_cnt_g)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [2:0] code, input logic v);
    in_valid = vld;
    code_i   = code;
    v_i      = v;
  endtask

  // Advance n rising edges and land on the following falling edge for sampling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] t2_codes [5];
    logic       seen;
    bit         found;
    int         rise_n [$];
    int         rise_g [$];
    int         high_g;
    logic       prev_n, prev_g;
    logic [5:0] o_at_rise_g;

    t2_codes = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd2};

    // ---- reset state and single-token latency ----
    rst       = 1'b1;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_o", o, 0);
    checkOutput("rst_err", err_o, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t1_lat_edge_k", out_valid, 0);
    tick(1);
    checkOutput("t1_valid_k1", out_valid, 1);
    checkOutput("t1_o", o, 6'b000100);
    tick(1);
    checkOutput("t1_single_cycle", out_valid, 0);
    checkOutput("t1_o_cleared", o, 0);

    // ---- fill with downstream stalled, then drain in order ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, t2_codes[i], 1'b1);
      tick(1);
      if (i == 3) checkOutput("t2_ready_after_4", in_ready, 1);
      if (i == 4) checkOutput("t2_ready_after_5", in_ready, 0);
    end
    applyStimulus(1'b1, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("t2_full_hold_%0d", i), in_ready, 0);
      checkOutput($sformatf("t2_o_stable_%0d", i), o, 6'b000001);
      checkOutput($sformatf("t2_valid_stable_%0d", i), out_valid, 1);
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        if (out_valid) found = 1'b1;
        else tick(1);
      end
      checkOutput($sformatf("t2_seen_%0d", i), found, 1);
      checkOutput($sformatf("t2_o_%0d", i), o, 6'(6'd1 << t2_codes[i]));
      tick(1);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= out_valid;
      tick(1);
    end
    checkOutput("t2_held_not_taken", seen, 0);

    // ---- illegal codes and err_o precedence ----
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t3_err_set", err_o, 1);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen |= out_valid;
      tick(1);
    end
    checkOutput("t3_no_output", seen, 0);
    checkOutput("t3_in_ready", in_ready, 1);
    err_clr = 1'b1;
    applyStimulus(1'b1, 3'd7, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t3_set_beats_clr", err_o, 1);
    tick(1);
    err_clr = 1'b0;
    checkOutput("t3_clr_alone", err_o, 0);
    applyStimulus(1'b1, 3'd6, 1'b0);
    tick(1);
    applyStimulus(1'b1, 3'd3, 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    seen = out_valid;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      seen |= out_valid;
    end
    checkOutput("t3_v0_no_err", err_o, 0);
    checkOutput("t3_v0_no_output", seen, 0);

    // ---- gap spacing: GAP_CYC=0 vs GAP_CYC=3 ----
    resetDut();
    out_ready = 1'b1;
    prev_n = 1'b0;
    prev_g = 1'b0;
    high_g = 0;
    o_at_rise_g = '0;
    for (int c = 0; c < 20; c++) begin
      if (c < 2) applyStimulus(1'b1, 3'd4, 1'b1);
      else       applyStimulus(1'b0, 3'd0, 1'b0);
      tick(1);
      if (out_valid && !prev_n) rise_n.push_back(c);
      if (out_valid_g && !prev_g) begin
        rise_g.push_back(c);
        o_at_rise_g = o_g;
      end
      if (out_valid_g) high_g++;
      prev_n = out_valid;
      prev_g = out_valid_g;
    end
    checkOutput("t4_gap_pulses", rise_g.size(), 2);
    checkOutput("t4_gap_high_cycles", high_g, 2);
    checkOutput("t4_gap_o", o_at_rise_g, 6'b010000);
    checkOutput("t4_nogap_pulses", rise_n.size(), 2);
    if (rise_g.size() == 2) checkOutput("t4_gap_spacing", rise_g[1] - rise_g[0], 5);
    if (rise_n.size() == 2) checkOutput("t4_nogap_spacing", rise_n[1] - rise_n[0], 2);

    // ---- reset while presenting with three entries queued ----
    resetDut();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b1);
      tick(1);
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t5_presenting", out_valid, 1);
    checkOutput("t5_o_before", o, 6'b000010);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_valid_async", out_valid, 0);
    checkOutput("t5_o_async", o, 0);
    checkOutput("t5_ready_async", in_ready, 0);
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      seen |= out_valid;
    end
    checkOutput("t5_no_stale", seen, 0);
    checkOutput("t5_ready_after", in_ready, 1);

`ifdef PRDEC_STATS_EN
    // ---- drop counter saturation ----
    resetDut();
    out_ready = 1'b1;
    checkOutput("t6_drop_rst", drop_cnt, 0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 3'(i % 8), 1'b0);
      tick(1);
      seen |= out_valid;
      if (i == 9) checkOutput("t6_drop_10", drop_cnt, 10);
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t6_drop_sat", drop_cnt, 255);
    checkOutput("t6_no_output", seen, 0);
    checkOutput("t6_no_err", err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
